// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, state encoding and constants for the MDU issue controller
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [MDU_XLEN-1:0] MDU_INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/mdu_special_case.sv
// rtl/mdu_special_case.sv - divide-by-zero and signed-overflow results resolved without the unit
module mdu_special_case
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_is_special,
  output logic [XLEN-1:0] o_special_result
);

  logic w_b_zero;
  logic w_ovf;

  assign w_b_zero = (i_b == '0);
  assign w_ovf    = (i_a == MDU_INT_MIN) && (i_b == '1);

  always_comb begin
    o_is_special     = 1'b0;
    o_special_result = '0;
    case (i_op)
      MDU_DIV: begin
        if (w_b_zero) begin
          o_is_special     = 1'b1;
          o_special_result = '1;
        end else if (w_ovf) begin
          o_is_special     = 1'b1;
          o_special_result = MDU_INT_MIN;
        end
      end
      MDU_DIVU: begin
        if (w_b_zero) begin
          o_is_special     = 1'b1;
          o_special_result = '1;
        end
      end
      MDU_REM: begin
        if (w_b_zero) begin
          o_is_special     = 1'b1;
          o_special_result = i_a;
        end else if (w_ovf) begin
          o_is_special     = 1'b1;
          o_special_result = '0;
        end
      end
      MDU_REMU: begin
        if (w_b_zero) begin
          o_is_special     = 1'b1;
          o_special_result = i_a;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - issues M-extension ops to the shared iterative unit and writes results back
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_ID,
  input  logic [2:0]      op_ID,
  input  logic [4:0]      rd_ID,
  input  logic [4:0]      rs1_ID,
  input  logic [4:0]      rs2_ID,
  input  logic            rs1use_ID,
  input  logic            rs2use_ID,
  input  logic            rd_we_ID,
  input  logic [XLEN-1:0] a_ID,
  input  logic [XLEN-1:0] b_ID,
  input  logic            kill_ID,
  output logic            unit_start,
  output logic [2:0]      unit_op,
  output logic [XLEN-1:0] unit_a,
  output logic [XLEN-1:0] unit_b,
  input  logic            unit_done,
  input  logic [XLEN-1:0] unit_result,
  input  logic            wb_free,
  output logic            mdu_wb_en,
  output logic [4:0]      mdu_wb_rd,
  output logic [XLEN-1:0] mdu_wb_data,
  output logic            stall_ID,
  output logic            busy
);

  logic [1:0]      r_state;
  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic            r_start;

  logic            w_busy;
  logic            w_hold;
  logic            w_s1;
  logic            w_s2;
  logic            w_s3;
  logic            w_accept;
  logic            w_is_special;
  logic [XLEN-1:0] w_special_result;

  mdu_special_case #(
    .XLEN(XLEN)
  ) u_special (
    .i_op            (op_ID),
    .i_a             (a_ID),
    .i_b             (b_ID),
    .o_is_special    (w_is_special),
    .o_special_result(w_special_result)
  );

  assign w_busy = (r_state != ST_IDLE);
  assign w_hold = (r_state == ST_HOLD);

  // Stall is built only from registered state and ID decode, never from the accept term.
  assign w_s1     = req_ID;
  assign w_s2     = (rs1use_ID && (rs1_ID == r_rd)) || (rs2use_ID && (rs2_ID == r_rd));
  assign w_s3     = rd_we_ID && (rd_ID == r_rd);
  assign stall_ID = w_busy && (w_s1 || w_s2 || w_s3);
  assign w_accept = req_ID && !kill_ID && !stall_ID;

  assign busy        = w_busy;
  assign unit_start  = r_start;
  assign unit_op     = r_op;
  assign unit_a      = r_a;
  assign unit_b      = r_b;
  assign mdu_wb_en   = w_hold && wb_free;
  assign mdu_wb_rd   = w_hold ? r_rd : 5'd0;
  assign mdu_wb_data = w_hold ? r_result : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= 3'd0;
      r_rd     <= 5'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_start  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= op_ID;
            r_rd <= rd_ID;
            r_a  <= a_ID;
            r_b  <= b_ID;
            // A write to x0 is architecturally a no-op, so it retires here.
            if (rd_ID != 5'd0) begin
              if (w_is_special) begin
                r_result <= w_special_result;
                r_state  <= ST_HOLD;
              end else begin
                r_state <= ST_RUN;
                r_start <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (!r_start && unit_done) begin
            r_result <= unit_result;
            r_state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (wb_free) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb/tb_mdu_issue_ctrl.sv - scoreboard bench for the MDU issue controller
module tb_mdu_issue_ctrl;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_ID;
  logic [2:0]      op_ID;
  logic [4:0]      rd_ID;
  logic [4:0]      rs1_ID;
  logic [4:0]      rs2_ID;
  logic            rs1use_ID;
  logic            rs2use_ID;
  logic            rd_we_ID;
  logic [XLEN-1:0] a_ID;
  logic [XLEN-1:0] b_ID;
  logic            kill_ID;
  logic            unit_start;
  logic [2:0]      unit_op;
  logic [XLEN-1:0] unit_a;
  logic [XLEN-1:0] unit_b;
  logic            unit_done;
  logic [XLEN-1:0] unit_result;
  logic            wb_free;
  logic            mdu_wb_en;
  logic [4:0]      mdu_wb_rd;
  logic [XLEN-1:0] mdu_wb_data;
  logic            stall_ID;
  logic            busy;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_ID     (req_ID),
    .op_ID      (op_ID),
    .rd_ID      (rd_ID),
    .rs1_ID     (rs1_ID),
    .rs2_ID     (rs2_ID),
    .rs1use_ID  (rs1use_ID),
    .rs2use_ID  (rs2use_ID),
    .rd_we_ID   (rd_we_ID),
    .a_ID       (a_ID),
    .b_ID       (b_ID),
    .kill_ID    (kill_ID),
    .unit_start (unit_start),
    .unit_op    (unit_op),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .unit_done  (unit_done),
    .unit_result(unit_result),
    .wb_free    (wb_free),
    .mdu_wb_en  (mdu_wb_en),
    .mdu_wb_rd  (mdu_wb_rd),
    .mdu_wb_data(mdu_wb_data),
    .stall_ID   (stall_ID),
    .busy       (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_starts = 0;
  int n_wb = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference arithmetic done at 64 bits so signed overflow falls out naturally.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    r  = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * $signed(ub)); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin if (b == 0) r = '1; else begin p = 64'(sa / sb); r = p[31:0]; end end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin if (b == 0) r = a; else begin p = 64'(sa % sb); r = p[31:0]; end end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  int          u_cnt;
  logic [31:0] u_res;
  logic        force_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_cnt <= 0;
      u_res <= '0;
    end else if (unit_start) begin
      u_cnt <= 3;
      u_res <= ref_result(unit_op, unit_a, unit_b);
    end else if (u_cnt > 0) begin
      u_cnt <= u_cnt - 1;
    end
  end

  always @(posedge clk) if (unit_start) n_starts <= n_starts + 1;

  assign unit_done   = (u_cnt == 1) || force_done;
  assign unit_result = u_res;

  always @(negedge clk) begin
    if (mdu_wb_en) begin
      wb_t e;
      n_wb++;
      if (sb_q.size() == 0) begin
        check_val("wb_unexpected_rd", 32'(mdu_wb_rd), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("wb_rd", 32'(mdu_wb_rd), 32'(e.rd));
        check_val("wb_data", mdu_wb_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_ID = 0; kill_ID = 0; op_ID = 0; rd_ID = 0; rs1_ID = 0; rs2_ID = 0;
    rs1use_ID = 0; rs2use_ID = 0; rd_we_ID = 0; a_ID = '0; b_ID = '0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit kill, input bit push);
    wb_t e;
    req_ID = 1; kill_ID = kill; op_ID = op; a_ID = a; b_ID = b; rd_ID = rd; rd_we_ID = 1;
    if (push && !kill && rd != 0) begin
      e.rd   = rd;
      e.data = ref_result(op, a, b);
      sb_q.push_back(e);
    end
    tick();
    drive_idle();
  endtask

  task automatic wait_wb(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (mdu_wb_en) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check_val("wb_timeout", 32'(mdu_wb_en), 32'd1);
    tick();
  endtask

  logic [2:0]  sp_op [6] = '{MDU_DIVU, MDU_REMU, MDU_DIV, MDU_REM, MDU_DIV, MDU_REM};
  logic [31:0] sp_a  [6] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
  logic [31:0] sp_b  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};

  logic [2:0]  un_op [7] = '{MDU_MUL, MDU_DIVU, MDU_MULHU, MDU_MULH, MDU_DIV, MDU_REM, MDU_MULHSU};
  logic [31:0] un_a  [7] = '{32'd7, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
  logic [31:0] un_b  [7] = '{32'd6, 32'd7, 32'hFFFF_FFFF, 32'd3, 32'd7, 32'd7, 32'hFFFF_FFFF};

  logic [4:0] hz_rs1 [10] = '{5, 6, 0, 0, 0, 0, 5, 5, 5, 5};
  bit         hz_u1  [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
  logic [4:0] hz_rs2 [10] = '{0, 0, 0, 5, 0, 0, 0, 0, 0, 0};
  bit         hz_u2  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  logic [4:0] hz_rd  [10] = '{0, 0, 1, 0, 5, 4, 0, 0, 0, 0};
  bit         hz_we  [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  bit         hz_req [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  bit         hz_wbf [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  bit         hz_stl [10] = '{1, 0, 1, 1, 1, 0, 1, 1, 1, 0};
  bit         hz_bsy [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  bit         hz_wen [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

  initial begin
    int cyc, s0, w0;
    drive_idle();
    wb_free = 1; force_done = 0; rst_n = 0;
    req_ID = 1; rd_ID = 5; rd_we_ID = 1; rs1use_ID = 1; a_ID = 32'd3; b_ID = 32'd4;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_start", 32'(unit_start), 32'd0);
    check_val("rst_stall", 32'(stall_ID), 32'd0);
    check_val("rst_wb_en", 32'(mdu_wb_en), 32'd0);
    check_val("rst_wb_rd", 32'(mdu_wb_rd), 32'd0);
    check_val("rst_wb_data", mdu_wb_data, 32'd0);
    check_val("rst_unit_a", unit_a, 32'd0);
    check_val("rst_unit_b", unit_b, 32'd0);
    check_val("rst_unit_op", 32'(unit_op), 32'd0);
    drive_idle();
    tick();
    rst_n = 1;
    tick();

    // first unit op: start pulse and latched operands in the cycle after accept
    s0 = n_starts;
    issue(MDU_MUL, 32'd7, 32'd6, 5'd5, 0, 1);
    @(negedge clk);
    check_val("mul_start", 32'(unit_start), 32'd1);
    check_val("mul_busy", 32'(busy), 32'd1);
    check_val("mul_unit_a", unit_a, 32'd7);
    check_val("mul_unit_b", unit_b, 32'd6);
    check_val("mul_unit_op", 32'(unit_op), 32'(MDU_MUL));
    tick();
    check_val("mul_start_pulse", 32'(unit_start), 32'd0);
    wait_wb(cyc);
    check_val("mul_wb_lat", 32'(cyc), 32'd4);
    @(negedge clk);
    check_val("mul_busy_fall", 32'(busy), 32'd0);
    tick();
    check_val("mul_n_starts", 32'(n_starts - s0), 32'd1);

    for (int k = 0; k < 6; k++) begin
      s0 = n_starts;
      issue(sp_op[k], sp_a[k], sp_b[k], 5'(3 + k), 0, 1);
      wait_wb(cyc);
      check_val("special_wb_lat", 32'(cyc), 32'd1);
      @(negedge clk);
      check_val("special_busy_fall", 32'(busy), 32'd0);
      tick();
      check_val("special_no_start", 32'(n_starts - s0), 32'd0);
    end

    for (int k = 1; k < 7; k++) begin
      s0 = n_starts;
      issue(un_op[k], un_a[k], un_b[k], 5'(10 + k), 0, 1);
      tick();
      wait_wb(cyc);
      check_val("unit_wb_lat", 32'(cyc), 32'd4);
      @(negedge clk);
      check_val("unit_busy_fall", 32'(busy), 32'd0);
      tick();
      check_val("unit_n_starts", 32'(n_starts - s0), 32'd1);
    end

    s0 = n_starts;
    issue(MDU_MUL, 32'd3, 32'd3, 5'd0, 0, 1);
    @(negedge clk);
    check_val("x0_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check_val("x0_no_start", 32'(n_starts - s0), 32'd0);

    issue(MDU_MUL, 32'd3, 32'd3, 5'd8, 1, 1);
    @(negedge clk);
    check_val("kill_busy", 32'(busy), 32'd0);
    tick();

    // hazards during RUN, then a blocked writeback port for four HOLD cycles
    wb_free = 0;
    w0 = n_wb;
    issue(MDU_MUL, 32'd3, 32'd5, 5'd5, 0, 1);
    for (int c = 0; c < 10; c++) begin
      rs1_ID = hz_rs1[c]; rs1use_ID = hz_u1[c]; rs2_ID = hz_rs2[c]; rs2use_ID = hz_u2[c];
      rd_ID = hz_rd[c]; rd_we_ID = hz_we[c]; req_ID = hz_req[c]; wb_free = hz_wbf[c];
      @(negedge clk);
      check_val($sformatf("hz_stall_c%0d", c + 1), 32'(stall_ID), 32'(hz_stl[c]));
      check_val($sformatf("hz_busy_c%0d", c + 1), 32'(busy), 32'(hz_bsy[c]));
      check_val($sformatf("hz_wb_en_c%0d", c + 1), 32'(mdu_wb_en), 32'(hz_wen[c]));
      tick();
    end
    drive_idle();
    wb_free = 1;
    check_val("hz_one_write", 32'(n_wb - w0), 32'd1);

    // reset in the middle of RUN discards the op
    issue(MDU_MUL, 32'd9, 32'd9, 5'd4, 0, 0);
    tick();
    req_ID = 1; rs1_ID = 5'd4; rs1use_ID = 1;
    rst_n = 0;
    #1;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_start", 32'(unit_start), 32'd0);
    check_val("midrst_unit_a", unit_a, 32'd0);
    check_val("midrst_unit_b", unit_b, 32'd0);
    check_val("midrst_stall", 32'(stall_ID), 32'd0);
    check_val("midrst_wb_en", 32'(mdu_wb_en), 32'd0);
    drive_idle();
    tick();
    rst_n = 1;
    tick();
    force_done = 1;
    @(negedge clk);
    check_val("late_done_idle_busy", 32'(busy), 32'd0);
    tick();
    force_done = 0;
    issue(MDU_MUL, 32'd11, 32'd12, 5'd9, 0, 1);
    force_done = 1;
    @(negedge clk);
    check_val("post_rst_start", 32'(unit_start), 32'd1);
    tick();
    force_done = 0;
    wait_wb(cyc);
    check_val("post_rst_wb_lat", 32'(cyc), 32'd4);
    @(negedge clk);
    check_val("post_rst_busy_fall", 32'(busy), 32'd0);
    tick();

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
